// File: rtl/tracker_pkg.sv
// -----------------------------------------------------------------------------
// tracker_pkg
// Shared definitions for the tracker frame controller: FSM state encoding,
// default frame geometry, and small constant helpers for sizing counters.
// -----------------------------------------------------------------------------
package tracker_pkg;

  // Frame controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  // Default resolution and blanking lengths.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_H_BLANK  = 16;
  localparam int DEF_V_BLANK  = 32;

  // Larger of two integers.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // clog2(n), never below 1 so a degenerate size still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tracker_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tracker_frame_ctrl
// Raster timing generator for the object tracker. Walks active pixels, line
// blanking and frame blanking, and stalls frame blanking until the downstream
// consumer has taken the bounding-box result.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-low reset
//   run         in   level; generate frames continuously while high
//   res_ready   in   downstream consumed the result; releases frame blanking
//   h_sync      out  high on active pixels
//   v_sync      out  high from first to last active pixel of a frame
//   x           out  active pixel column (XW bits)
//   y           out  active line (YW bits)
//   frame_start out  one-cycle pulse on pixel (0,0)
//   frame_done  out  one-cycle pulse on the first frame-blanking cycle
//   frame_cnt   out  completed-frame count, wraps at 16 bits
//   busy        out  high whenever the FSM is not idle
// All outputs are registered.
// -----------------------------------------------------------------------------
module tracker_frame_ctrl
  import tracker_pkg::*;
#(
  parameter int  H_ACTIVE = DEF_H_ACTIVE,
  parameter int  V_ACTIVE = DEF_V_ACTIVE,
  parameter int  H_BLANK  = DEF_H_BLANK,
  parameter int  V_BLANK  = DEF_V_BLANK,
  localparam int XW       = cnt_width(H_ACTIVE),
  localparam int YW       = cnt_width(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          res_ready,
  output logic          h_sync,
  output logic          v_sync,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          busy
);

  // The blanking counter must reach the larger of the two blanking lengths.
  localparam int BW = cnt_width(max2(H_BLANK, V_BLANK) + 1);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] H_LIM  = BW'(H_BLANK);
  localparam logic [BW-1:0] V_LIM  = BW'(V_BLANK);

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [BW-1:0] r_blank_cnt;
  logic [15:0]   r_frame_cnt;
  logic          r_h_sync;
  logic          r_v_sync;
  logic          r_frame_start;
  logic          r_frame_done;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic [BW-1:0] w_blank_nxt;
  logic [15:0]   w_frame_cnt_nxt;
  logic          w_start_nxt;
  logic          w_done_nxt;

  // Next-state, counter and pulse logic; outputs follow the next state so
  // they are registered together with it.
  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_blank_nxt     = r_blank_cnt;
    w_frame_cnt_nxt = r_frame_cnt;
    w_start_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_x_nxt     = {XW{1'b0}};
        w_y_nxt     = {YW{1'b0}};
        w_blank_nxt = {BW{1'b0}};
        if (run) begin
          w_state_nxt = ST_ACTIVE;
          w_start_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // x stays on the last column through blanking; the blank counter
        // starts at 1 so it directly equals the blanking cycle number.
        if (r_x == X_LAST) begin
          w_blank_nxt = BW'(1);
          if (r_y == Y_LAST) begin
            w_state_nxt     = ST_VBLANK;
            w_done_nxt      = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          end else begin
            w_state_nxt = ST_HBLANK;
          end
        end else begin
          w_x_nxt = r_x + XW'(1);
        end
      end
      ST_HBLANK: begin
        if (r_blank_cnt >= H_LIM) begin
          w_state_nxt = ST_ACTIVE;
          w_x_nxt     = {XW{1'b0}};
          w_y_nxt     = r_y + YW'(1);
          w_blank_nxt = {BW{1'b0}};
        end else begin
          w_blank_nxt = r_blank_cnt + BW'(1);
        end
      end
      ST_VBLANK: begin
        // Minimum length first, then wait for the consumer; the counter
        // saturates at V_BLANK while stalled.
        if ((r_blank_cnt >= V_LIM) && res_ready) begin
          w_x_nxt     = {XW{1'b0}};
          w_y_nxt     = {YW{1'b0}};
          w_blank_nxt = {BW{1'b0}};
          if (run) begin
            w_state_nxt = ST_ACTIVE;
            w_start_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (r_blank_cnt < V_LIM) begin
          w_blank_nxt = r_blank_cnt + BW'(1);
        end else begin
          w_blank_nxt = r_blank_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_x_nxt     = {XW{1'b0}};
        w_y_nxt     = {YW{1'b0}};
        w_blank_nxt = {BW{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_x           <= {XW{1'b0}};
      r_y           <= {YW{1'b0}};
      r_blank_cnt   <= {BW{1'b0}};
      r_frame_cnt   <= 16'd0;
      r_h_sync      <= 1'b0;
      r_v_sync      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_blank_cnt   <= w_blank_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_h_sync      <= (w_state_nxt == ST_ACTIVE);
      r_v_sync      <= (w_state_nxt == ST_ACTIVE) || (w_state_nxt == ST_HBLANK);
      r_frame_start <= w_start_nxt;
      r_frame_done  <= w_done_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
    end
  end

  assign h_sync      = r_h_sync;
  assign v_sync      = r_v_sync;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = r_busy;

endmodule
